// File: rtl/usb_pkt_tx_pkg.sv
// ============================================================================
// usb_pkt_tx_pkg
// ----------------------------------------------------------------------------
// Shared types and constants for the USB packet transmitter slice:
//   - pid_e      : 4-bit USB packet identifiers
//   - state_e    : transmitter FSM states
//   - CRC16_*    : data CRC polynomial, init value, good-packet residual
//   - MAX_PKT_LEN: payload cap used when USB_PKT_TX_LEN_CHECK_EN is defined
//   - isDataPid(): true for DATA0/DATA1/DATA2/MDATA
// ============================================================================
package usb_pkt_tx_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_DATA2 = 4'b0111,
        PID_MDATA = 4'b1111,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110,
        PID_NYET  = 4'b0110,
        PID_PRE   = 4'b1100,
        PID_SPLIT = 4'b1000,
        PID_PING  = 4'b0100
    } pid_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP,
        ST_GAP
    } state_e;

    // Mirror a 16-bit word end for end. The CRC engine shifts right because
    // bytes go out LSB first, so it needs the bit-reversed polynomial.
    function automatic logic [15:0] reflect16(input logic [15:0] value);
        logic [15:0] result;
        for (int i = 0; i < 16; i++) begin
            result[i] = value[15 - i];
        end
        return result;
    endfunction

    localparam logic [15:0] CRC16_POLY           = 16'h8005;
    localparam logic [15:0] CRC16_POLY_REFLECTED = reflect16(CRC16_POLY);
    localparam logic [15:0] CRC16_INIT           = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL       = 16'h800D;
    localparam int unsigned MAX_PKT_LEN          = 64;

    // Data PIDs are the only ones that carry a payload and a CRC16.
    function automatic logic isDataPid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1) ||
               (pid == PID_DATA2) || (pid == PID_MDATA);
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// ============================================================================
// usb_crc16
// ----------------------------------------------------------------------------
// Byte-wide USB data CRC16 (poly 0x8005, init 0xFFFF, bits LSB first).
// The register is kept in reflected form, so the ones-complement of its low
// byte is the first CRC byte on the wire and the high byte is the second.
//
// Ports:
//   i_clk     clock
//   i_reset   synchronous active-high reset (CRC back to init)
//   i_clear   reload the init value (start of a new packet)
//   i_enable  fold i_data into the CRC this cycle
//   i_data    payload byte
//   o_crc     current CRC register (not complemented)
// ============================================================================
module usb_crc16
    import usb_pkt_tx_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;
    logic [15:0] w_crcNext;

    // Eight reflected shift steps per byte; bit 0 of the byte is consumed first.
    function automatic logic [15:0] crcByte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] acc;
        acc = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (acc[0]) begin
                acc = (acc >> 1) ^ CRC16_POLY_REFLECTED;
            end else begin
                acc = acc >> 1;
            end
        end
        return acc;
    endfunction

    // Next CRC value if the current byte were folded in.
    always_comb begin
        w_crcNext = crcByte(r_crc, i_data);
    end

    // Clear wins over enable so a packet always starts from the init value.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_crc <= CRC16_INIT;
        end else if (i_enable) begin
            r_crc <= w_crcNext;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/usb_pkt_tx.sv
// ============================================================================
// usb_pkt_tx
// ----------------------------------------------------------------------------
// USB packet transmit sequencer. Accepts a send request with a PID, then
// feeds the transceiver PID byte, optional payload bytes pulled from an
// endpoint buffer, the CRC16 (low byte first), drops tx_valid for EOP and
// waits IPG_CYCLES idle cycles before accepting the next packet.
//
// Parameters:
//   IPG_CYCLES     idle cycles spent in GAP after EOP (default 16)
//
// Build option:
//   USB_PKT_TX_LEN_CHECK_EN  when defined, payload is capped at MAX_PKT_LEN
//                            bytes; otherwise no byte counter exists.
//
// Ports:
//   i_clk          24 MHz system clock
//   i_reset        synchronous active-high reset
//   i_pid          PID to send, sampled with i_send
//   i_send         one-cycle request, honoured only in IDLE
//   o_busy         high from accepted send until back in IDLE
//   o_done         one-cycle pulse on return to IDLE
//   i_data         payload byte from endpoint buffer
//   i_data_valid   payload byte available
//   o_data_ready   one-cycle pulse, payload byte consumed
//   o_tx_data      byte to transceiver
//   o_tx_valid     rise = SYNC, high = sending, fall = EOP
//   i_tx_ready     one-cycle pulse, current o_tx_data taken
// ============================================================================
module usb_pkt_tx
    import usb_pkt_tx_pkg::*;
#(
    parameter int unsigned IPG_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_pid,
    input  logic       i_send,
    output logic       o_busy,
    output logic       o_done,
    input  logic [7:0] i_data,
    input  logic       i_data_valid,
    output logic       o_data_ready,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready
);

    state_e      r_state;
    state_e      w_stateNext;
    logic [3:0]  r_pid;
    logic [3:0]  w_pidNext;
    logic [7:0]  r_txData;
    logic [7:0]  w_txDataNext;
    logic        r_txValid;
    logic        w_txValidNext;
    logic        r_busy;
    logic        w_busyNext;
    logic        r_done;
    logic        w_doneNext;
    logic        r_dataReady;
    logic        w_dataReadyNext;
    logic [15:0] r_gapCount;
    logic [15:0] w_gapCountNext;
    logic        w_crcClear;
    logic        w_crcEnable;
    logic [15:0] w_crc;
    logic        w_consume;
    logic        w_lenReached;
    logic        w_takePayload;

`ifdef USB_PKT_TX_LEN_CHECK_EN
    logic [6:0]  r_byteCount;
    logic [6:0]  w_byteCountNext;

    assign w_lenReached = (r_byteCount == 7'(MAX_PKT_LEN));
`else
    assign w_lenReached = 1'b0;
`endif

    // A byte only counts as taken while we are actually presenting one;
    // stray tx_ready pulses during EOP/GAP/IDLE fall out here.
    assign w_consume     = r_txValid & i_tx_ready;
    assign w_takePayload = i_data_valid & ~w_lenReached;

    usb_crc16 u_crc (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_crcClear),
        .i_enable (w_crcEnable),
        .i_data   (i_data),
        .o_crc    (w_crc)
    );

    // Next-state and next-output logic. Every output is computed here one
    // cycle early and registered below, so a new tx_data shows up the cycle
    // after the tx_ready that consumed the previous one and is otherwise held.
    // data_valid is looked at only when the PID or a payload byte is consumed;
    // if it is low then, the payload is over and the CRC follows.
    always_comb begin
        w_stateNext     = r_state;
        w_pidNext       = r_pid;
        w_txDataNext    = r_txData;
        w_txValidNext   = r_txValid;
        w_busyNext      = r_busy;
        w_doneNext      = 1'b0;
        w_dataReadyNext = 1'b0;
        w_gapCountNext  = r_gapCount;
        w_crcClear      = 1'b0;
        w_crcEnable     = 1'b0;
`ifdef USB_PKT_TX_LEN_CHECK_EN
        w_byteCountNext = r_byteCount;
`endif

        case (r_state)
            ST_IDLE: begin
                if (i_send) begin
                    w_pidNext     = i_pid;
                    w_txDataNext  = {~i_pid, i_pid};
                    w_txValidNext = 1'b1;
                    w_busyNext    = 1'b1;
                    w_crcClear    = 1'b1;
                    w_stateNext   = ST_PID;
`ifdef USB_PKT_TX_LEN_CHECK_EN
                    w_byteCountNext = 7'd0;
`endif
                end
            end

            ST_PID, ST_DATA: begin
                if (w_consume) begin
                    if ((r_state == ST_PID) && !isDataPid(r_pid)) begin
                        w_txValidNext = 1'b0;
                        w_stateNext   = ST_EOP;
                    end else if (w_takePayload) begin
                        w_txDataNext    = i_data;
                        w_dataReadyNext = 1'b1;
                        w_crcEnable     = 1'b1;
                        w_stateNext     = ST_DATA;
`ifdef USB_PKT_TX_LEN_CHECK_EN
                        w_byteCountNext = r_byteCount + 7'd1;
`endif
                    end else begin
                        w_txDataNext = ~w_crc[7:0];
                        w_stateNext  = ST_CRC_LO;
                    end
                end
            end

            ST_CRC_LO: begin
                if (w_consume) begin
                    w_txDataNext = ~w_crc[15:8];
                    w_stateNext  = ST_CRC_HI;
                end
            end

            ST_CRC_HI: begin
                if (w_consume) begin
                    w_txValidNext = 1'b0;
                    w_stateNext   = ST_EOP;
                end
            end

            ST_EOP: begin
                w_gapCountNext = 16'd0;
                w_stateNext    = ST_GAP;
            end

            ST_GAP: begin
                if ((32'(r_gapCount) + 32'd1) >= 32'(IPG_CYCLES)) begin
                    w_gapCountNext = 16'd0;
                    w_busyNext     = 1'b0;
                    w_doneNext     = 1'b1;
                    w_stateNext    = ST_IDLE;
                end else begin
                    w_gapCountNext = r_gapCount + 16'd1;
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Registered outputs, latched PID and counters. Reset mid-packet simply
    // abandons the packet: tx_valid drops and no done pulse is produced.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pid       <= 4'h0;
            r_txData    <= 8'h00;
            r_txValid   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dataReady <= 1'b0;
            r_gapCount  <= 16'd0;
`ifdef USB_PKT_TX_LEN_CHECK_EN
            r_byteCount <= 7'd0;
`endif
        end else begin
            r_pid       <= w_pidNext;
            r_txData    <= w_txDataNext;
            r_txValid   <= w_txValidNext;
            r_busy      <= w_busyNext;
            r_done      <= w_doneNext;
            r_dataReady <= w_dataReadyNext;
            r_gapCount  <= w_gapCountNext;
`ifdef USB_PKT_TX_LEN_CHECK_EN
            r_byteCount <= w_byteCountNext;
`endif
        end
    end

    assign o_tx_data    = r_txData;
    assign o_tx_valid   = r_txValid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_data_ready = r_dataReady;

endmodule

// File: tb/tb_usb_pkt_tx.sv
// ============================================================================
// tb_usb_pkt_tx
// ----------------------------------------------------------------------------
// Self-checking bench for usb_pkt_tx. A transceiver/endpoint driver pushes
// random payloads and random tx_ready spacing; expected byte streams come
// from a bit-serial CRC16 model written in plain polynomial form.
// Honours USB_PKT_TX_LEN_CHECK_EN for the payload-cap expectations.
// ============================================================================
module tb_usb_pkt_tx;

    localparam int IPG = 16;

`ifdef USB_PKT_TX_LEN_CHECK_EN
    localparam int LEN_CAP = 64;
`else
    localparam int LEN_CAP = 1000000;
`endif

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic [3:0] pid       = 4'h0;
    logic       send      = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] data      = 8'h00;
    logic       dataValid = 1'b0;
    logic       dataReady;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady   = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] payload [0:127];
    logic [7:0] capBytes [$];
    logic [7:0] expBytes [$];
    int readyPulses;
    int doneSeen;
    int doneDelay;
    int fellAt;
    int stableErr;
    int busyErr;
    int dataIdx;
    int nOffered;

    logic [3:0] dataPids  [0:3] = '{4'b0011, 4'b1011, 4'b0111, 4'b1111};
    logic [3:0] hsPids    [0:7] = '{4'b0010, 4'b1010, 4'b1110, 4'b0110,
                                    4'b0001, 4'b1001, 4'b0101, 4'b1101};

    // 100 MHz-ish bench clock; the absolute rate does not matter to the DUT.
    always #5 clk = ~clk;

    usb_pkt_tx #(.IPG_CYCLES(IPG)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_pid        (pid),
        .i_send       (send),
        .o_busy       (busy),
        .o_done       (done),
        .i_data       (data),
        .i_data_valid (dataValid),
        .o_data_ready (dataReady),
        .o_tx_data    (txData),
        .o_tx_valid   (txValid),
        .i_tx_ready   (txReady)
    );

    // Safety net so a wedged DUT can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit modelIsData(input logic [3:0] p);
        return (p == 4'b0011) || (p == 4'b1011) || (p == 4'b0111) || (p == 4'b1111);
    endfunction

    // Polynomial-form CRC16: x^15 on the left, message bits fed LSB first,
    // result complemented and mirrored into wire order (low byte first).
    function automatic logic [15:0] modelCrcField(input int n);
        logic [15:0] r;
        logic [15:0] rev;
        logic        fb;
        r = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = payload[i][b] ^ r[15];
                r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        for (int k = 0; k < 16; k++) begin
            rev[k] = r[15 - k];
        end
        return ~rev;
    endfunction

    function automatic int expectedPayload(input logic [3:0] p, input int n);
        if (!modelIsData(p)) return 0;
        return (n > LEN_CAP) ? LEN_CAP : n;
    endfunction

    function automatic void buildExpected(input logic [3:0] p, input int n);
        int          sent;
        logic [15:0] c;
        expBytes.delete();
        expBytes.push_back({~p, p});
        if (modelIsData(p)) begin
            sent = expectedPayload(p, n);
            for (int i = 0; i < sent; i++) expBytes.push_back(payload[i]);
            c = modelCrcField(sent);
            expBytes.push_back(c[7:0]);
            expBytes.push_back(c[15:8]);
        end
    endfunction

    // Issue one send and play transceiver + endpoint until done (or timeout).
    // All sampling and driving happens on the falling edge.
    task automatic applyStimulus(input logic [3:0] p, input int n, input int firstDelay,
                                 input int gapMax, input bit noise);
        int         cyc;
        bit         prevValid;
        bit         prevConsumed;
        bit         sawValid;
        logic [7:0] prevData;
        capBytes.delete();
        readyPulses = 0; doneSeen = 0; doneDelay = -1; fellAt = -1;
        stableErr = 0; busyErr = 0; dataIdx = 0; nOffered = n;
        dataValid = (n > 0);
        data = payload[0];
        pid = p;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        cyc = 0; prevValid = 0; prevConsumed = 0; sawValid = 0; prevData = 8'h00;
        while (cyc < 3000 && doneSeen == 0) begin
            if (dataReady === 1'b1) begin
                readyPulses++;
                dataIdx++;
            end
            dataValid = (dataIdx < nOffered);
            data = (dataIdx < 128) ? payload[dataIdx] : 8'h00;
            if (prevValid && txValid === 1'b1 && !prevConsumed && txData !== prevData) stableErr++;
            if (txValid === 1'b1) sawValid = 1;
            else if (sawValid && fellAt < 0) fellAt = cyc;
            if (done === 1'b1) begin
                doneSeen = 1;
                doneDelay = cyc - fellAt;
                if (busy !== 1'b0) busyErr++;
            end else if (busy !== 1'b1) begin
                busyErr++;
            end
            txReady = 1'b0;
            send = 1'b0;
            if (txValid === 1'b1 && done !== 1'b1) begin
                if (cyc >= firstDelay && $urandom_range(0, gapMax) == 0) begin
                    txReady = 1'b1;
                    capBytes.push_back(txData);
                end
            end else if (noise && done !== 1'b1) begin
                txReady = 1'($urandom_range(0, 1));
            end
            if (noise && done !== 1'b1) begin
                send = 1'($urandom_range(0, 1));
                pid = 4'($urandom);
            end
            prevValid = (txValid === 1'b1);
            prevConsumed = txReady;
            prevData = txData;
            if (doneSeen == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        txReady = 1'b0;
        send = 1'b0;
        dataValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (txValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_valid: got %b, expected 0", txValid); end
        checks++; if (txData !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data: got %h, expected 00", txData); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
        checks++; if (dataReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_data_ready: got %b, expected 0", dataReady); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (txValid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset: tx_valid=%b busy=%b, expected 0 0", txValid, busy); end
    endtask

    task automatic test_handshake_ack();
        applyStimulus(4'b0010, 0, 10, 0, 1'b0);
        checks++; if (capBytes.size() != 1) begin failures++; $display("[TB] FAIL ack_len: got %0d bytes, expected 1", capBytes.size()); end
        checks++; if (capBytes.size() < 1 || capBytes[0] !== 8'hD2) begin failures++; $display("[TB] FAIL ack_byte: got %h, expected d2", (capBytes.size() > 0) ? capBytes[0] : 8'hxx); end
        checks++; if (doneSeen != 1 || doneDelay != IPG + 1) begin failures++; $display("[TB] FAIL ack_done_delay: seen=%0d delay=%0d, expected 1 %0d", doneSeen, doneDelay, IPG + 1); end
        checks++; if (stableErr != 0 || busyErr != 0 || readyPulses != 0) begin failures++; $display("[TB] FAIL ack_protocol: stable=%0d busy=%0d ready=%0d, expected 0 0 0", stableErr, busyErr, readyPulses); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || txValid !== 1'b0) begin failures++; $display("[TB] FAIL ack_done_width: done=%b busy=%b tx_valid=%b, expected 0 0 0", done, busy, txValid); end
    endtask

    task automatic test_zero_length();
        applyStimulus(4'b0011, 0, 0, 2, 1'b0);
        buildExpected(4'b0011, 0);
        checks++; if (capBytes.size() != 3) begin failures++; $display("[TB] FAIL zlp_len: got %0d bytes, expected 3", capBytes.size()); end
        for (int i = 0; i < expBytes.size(); i++) begin
            checks++;
            if (i >= capBytes.size() || capBytes[i] !== expBytes[i]) begin
                failures++;
                $display("[TB] FAIL zlp_byte%0d: got %h, expected %h", i, (i < capBytes.size()) ? capBytes[i] : 8'hxx, expBytes[i]);
            end
        end
        checks++; if (doneSeen != 1 || doneDelay != IPG + 1 || readyPulses != 0) begin failures++; $display("[TB] FAIL zlp_done: seen=%0d delay=%0d ready=%0d, expected 1 %0d 0", doneSeen, doneDelay, readyPulses, IPG + 1); end
    endtask

    task automatic test_data_fixed();
        for (int i = 0; i < 128; i++) payload[i] = 8'(i);
        applyStimulus(4'b1011, 4, 0, 1, 1'b0);
        buildExpected(4'b1011, 4);
        checks++; if (capBytes.size() != 7) begin failures++; $display("[TB] FAIL data1_len: got %0d bytes, expected 7", capBytes.size()); end
        for (int i = 0; i < expBytes.size(); i++) begin
            checks++;
            if (i >= capBytes.size() || capBytes[i] !== expBytes[i]) begin
                failures++;
                $display("[TB] FAIL data1_byte%0d: got %h, expected %h", i, (i < capBytes.size()) ? capBytes[i] : 8'hxx, expBytes[i]);
            end
        end
        checks++; if (readyPulses != 4) begin failures++; $display("[TB] FAIL data1_ready_pulses: got %0d, expected 4", readyPulses); end
        checks++; if (doneSeen != 1 || stableErr != 0 || busyErr != 0) begin failures++; $display("[TB] FAIL data1_protocol: done=%0d stable=%0d busy=%0d, expected 1 0 0", doneSeen, stableErr, busyErr); end
    endtask

    task automatic test_random_data();
        logic [3:0] p;
        int         n;
        for (int k = 0; k < 6; k++) begin
            p = dataPids[$urandom_range(0, 3)];
            n = $urandom_range(0, 20);
            for (int i = 0; i < 128; i++) payload[i] = 8'($urandom);
            applyStimulus(p, n, 0, $urandom_range(0, 3), 1'b0);
            buildExpected(p, n);
            checks++; if (capBytes.size() != expBytes.size()) begin failures++; $display("[TB] FAIL rand_len pkt%0d: got %0d bytes, expected %0d", k, capBytes.size(), expBytes.size()); end
            for (int i = 0; i < expBytes.size(); i++) begin
                checks++;
                if (i >= capBytes.size() || capBytes[i] !== expBytes[i]) begin
                    failures++;
                    $display("[TB] FAIL rand_byte pkt%0d idx%0d: got %h, expected %h", k, i, (i < capBytes.size()) ? capBytes[i] : 8'hxx, expBytes[i]);
                end
            end
            checks++; if (readyPulses != n) begin failures++; $display("[TB] FAIL rand_ready pkt%0d: got %0d, expected %0d", k, readyPulses, n); end
            checks++; if (doneSeen != 1 || doneDelay != IPG + 1 || stableErr != 0 || busyErr != 0) begin failures++; $display("[TB] FAIL rand_protocol pkt%0d: done=%0d delay=%0d stable=%0d busy=%0d, expected 1 %0d 0 0", k, doneSeen, doneDelay, stableErr, busyErr, IPG + 1); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] p;
        for (int k = 0; k < 4; k++) begin
            p = hsPids[$urandom_range(0, 7)];
            applyStimulus(p, 3, 0, 2, 1'b0);
            checks++;
            if (capBytes.size() != 1 || capBytes[0] !== {~p, p}) begin
                failures++;
                $display("[TB] FAIL b2b_handshake pkt%0d: got %0d bytes first=%h, expected 1 byte %h", k, capBytes.size(), (capBytes.size() > 0) ? capBytes[0] : 8'hxx, {~p, p});
            end
            checks++; if (readyPulses != 0 || doneSeen != 1 || busyErr != 0) begin failures++; $display("[TB] FAIL b2b_protocol pkt%0d: ready=%0d done=%0d busy=%0d, expected 0 1 0", k, readyPulses, doneSeen, busyErr); end
        end
    endtask

    task automatic test_len_cap();
        int expN;
        for (int i = 0; i < 128; i++) payload[i] = 8'($urandom);
        applyStimulus(4'b0011, 70, 0, 1, 1'b0);
        buildExpected(4'b0011, 70);
        expN = expectedPayload(4'b0011, 70);
        checks++; if (readyPulses != expN) begin failures++; $display("[TB] FAIL cap_ready_pulses: got %0d, expected %0d", readyPulses, expN); end
        checks++; if (capBytes.size() != expBytes.size()) begin failures++; $display("[TB] FAIL cap_len: got %0d bytes, expected %0d", capBytes.size(), expBytes.size()); end
        checks++;
        if (capBytes.size() != expBytes.size() ||
            capBytes[capBytes.size() - 2] !== expBytes[expBytes.size() - 2] ||
            capBytes[capBytes.size() - 1] !== expBytes[expBytes.size() - 1]) begin
            failures++;
            $display("[TB] FAIL cap_crc: got %0d bytes, expected CRC %h %h", capBytes.size(), expBytes[expBytes.size() - 2], expBytes[expBytes.size() - 1]);
        end
        checks++; if (doneSeen != 1 || stableErr != 0) begin failures++; $display("[TB] FAIL cap_protocol: done=%0d stable=%0d, expected 1 0", doneSeen, stableErr); end
    endtask

    task automatic test_send_ignored();
        int extra;
        for (int i = 0; i < 128; i++) payload[i] = 8'($urandom);
        applyStimulus(4'b0111, 5, 0, 2, 1'b1);
        buildExpected(4'b0111, 5);
        checks++; if (capBytes.size() != expBytes.size()) begin failures++; $display("[TB] FAIL ignore_len: got %0d bytes, expected %0d", capBytes.size(), expBytes.size()); end
        for (int i = 0; i < expBytes.size(); i++) begin
            checks++;
            if (i >= capBytes.size() || capBytes[i] !== expBytes[i]) begin
                failures++;
                $display("[TB] FAIL ignore_byte%0d: got %h, expected %h", i, (i < capBytes.size()) ? capBytes[i] : 8'hxx, expBytes[i]);
            end
        end
        checks++; if (doneSeen != 1 || doneDelay != IPG + 1 || busyErr != 0) begin failures++; $display("[TB] FAIL ignore_done: seen=%0d delay=%0d busy=%0d, expected 1 %0d 0", doneSeen, doneDelay, busyErr, IPG + 1); end
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (txValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("[TB] FAIL ignore_second_packet: %0d active cycles, expected 0", extra); end
    endtask

    task automatic test_reset_mid_packet();
        int pulses;
        int activity;
        pulses = 0;
        pid = 4'b0011;
        dataValid = 1'b1;
        data = 8'hA5;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        for (int c = 0; c < 200 && pulses < 3; c++) begin
            if (dataReady === 1'b1) pulses++;
            txReady = (txValid === 1'b1);
            @(negedge clk);
        end
        checks++; if (pulses < 3) begin failures++; $display("[TB] FAIL rst_reach_data: got %0d pulses, expected 3", pulses); end
        txReady = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (txValid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_outputs: tx_valid=%b busy=%b, expected 0 0", txValid, busy); end
        checks++; if (txData !== 8'h00 || dataReady !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_regs: tx_data=%h data_ready=%b done=%b, expected 00 0 0", txData, dataReady, done); end
        reset = 1'b0;
        dataValid = 1'b0;
        activity = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || txValid !== 1'b0) activity++;
        end
        checks++; if (activity != 0) begin failures++; $display("[TB] FAIL rst_no_done: %0d active cycles, expected 0", activity); end
        applyStimulus(4'b0010, 0, 0, 1, 1'b0);
        checks++; if (capBytes.size() != 1 || capBytes[0] !== 8'hD2) begin failures++; $display("[TB] FAIL rst_then_ack: got %0d bytes first=%h, expected 1 byte d2", capBytes.size(), (capBytes.size() > 0) ? capBytes[0] : 8'hxx); end
        checks++; if (doneSeen != 1 || doneDelay != IPG + 1) begin failures++; $display("[TB] FAIL rst_then_ack_done: seen=%0d delay=%0d, expected 1 %0d", doneSeen, doneDelay, IPG + 1); end
    endtask

    // Test sequence.
    initial begin
        for (int i = 0; i < 128; i++) payload[i] = 8'h00;
        $display("[TB] starting usb_pkt_tx bench");
        test_reset();
        test_handshake_ack();
        test_zero_length();
        test_data_fixed();
        test_random_data();
        test_back_to_back();
        test_len_cap();
        test_send_ignored();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_pkt_tx.md
USB_PKT_TX -- requirements
Module: usb_pkt_tx

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter IPG_CYCLES, default 16: idle clk cycles after EOP before a new packet is accepted.
REQ-003 Port clk  input  1  system clock (24 MHz).
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Port pid  input  4  PID to send, sampled with send.
REQ-006 Port send  input  1  one-cycle request pulse, honoured only in IDLE.
REQ-007 Port busy  output  1  high from accepted send until return to IDLE.
REQ-008 Port done  output  1  one-cycle pulse on return to IDLE.
REQ-009 Port data  input  8  payload byte from endpoint buffer.
REQ-010 Port data_valid  input  1  payload byte available on data.
REQ-011 Port data_ready  output  1  one-cycle pulse, payload byte consumed.
REQ-012 Port tx_data  output  8  byte to transceiver.
REQ-013 Port tx_valid  output  1  rise: SYNC, high: send, fall: EOP.
REQ-014 Port tx_ready  input  1  one-cycle pulse, current tx_data taken by serializer.

Function
REQ-015 FSM states SHALL be IDLE, PID, DATA, CRC_LO, CRC_HI, EOP, GAP.
REQ-016 IDLE + send: latch pid, go to PID; tx_valid=1 and tx_data={~pid,pid} on the next cycle; send outside IDLE ignored.
REQ-017 All outputs SHALL be registered; a new tx_data SHALL appear the cycle after the tx_ready that consumed the previous byte, and be held stable otherwise.
REQ-018 PID byte consumed, pid not DATA0(0011)/DATA1(1011)/DATA2(0111)/MDATA(1111): go to EOP (handshake, PID only).
REQ-019 PID or DATA byte consumed, data PID: if data_valid=1, load data to tx_data, pulse data_ready same cycle, stay/enter DATA; else go to CRC_LO.
REQ-020 CRC16: poly 0x8005, init 0xFFFF, LSB-first per byte, updated over payload bytes only; transmitted value is the ones-complement, low byte (CRC_LO) then high byte (CRC_HI).
REQ-021 Zero-length data packet SHALL send PID, 0x00, 0x00.
REQ-022 CRC_HI byte consumed: tx_valid=0 next cycle (EOP), enter GAP.
REQ-023 GAP SHALL count IPG_CYCLES cycles, then IDLE with done=1 for one cycle; busy drops in the same cycle.
REQ-024 data_valid sampled only at the tx_ready decision point; deassertion there ends the payload, no underrun error exists.
REQ-025 tx_ready while tx_valid=0 SHALL be ignored.

Reset
REQ-026 Reset SHALL force IDLE, tx_valid=0, tx_data=0x00, busy=0, done=0, data_ready=0, CRC=0xFFFF, counters 0, effective next cycle, including mid-packet (truncated packet, no done).

Configuration
REQ-027 Macro USB_PKT_TX_LEN_CHECK_EN defined: payload capped at 64 bytes; at count 64 the block SHALL go to CRC_LO without asserting data_ready, regardless of data_valid.
REQ-028 Macro undefined: payload length unbounded, no byte counter synthesized.

Structure
REQ-029 Package types SHALL hold the PID enum, CRC16 polynomial/init/residual constants and MAX_PKT_LEN (64).
REQ-030 Sub-module usb_crc16 SHALL implement the byte-wide CRC16 update (clear, enable, data in, crc out).

Verification
REQ-031 send, pid=0010 (ACK), tx_ready after 10 cycles -> tx_data=0xD2 then tx_valid falls, done after IPG_CYCLES+1 cycles.
REQ-032 send, pid=0011, data_valid=0 -> bytes 0xC3, 0x00, 0x00, then EOP.
REQ-033 send, pid=1011, payload 00 01 02 03 -> 0x4B, 00 01 02 03, CRC bytes matching a bit-serial reference model; 4 data_ready pulses.
REQ-034 LEN_CHECK_EN, 70 bytes offered -> exactly 64 data_ready pulses, then CRC over 64 bytes.
REQ-035 reset asserted during DATA -> tx_valid=0 and busy=0 next cycle, no done; following send of ACK transmitted correctly.
REQ-036 send during GAP and busy -> ignored; no second packet.
